// File: rtl/native_axil_bridge_if.sv
// Native memory request port plus AXI4-Lite master channels of the bridge.
// master = the bridge; slave = the core and RAM around it.
interface native_axil_bridge_if;
  // Each channel transfers on a rising clk edge where valid && ready are both high.
  // A sender holds valid and its payload stable until that edge. A receiver may
  // change ready freely.
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        axi_awvalid;
  logic        axi_awready;
  logic [31:0] axi_awaddr;
  logic        axi_wvalid;
  logic        axi_wready;
  logic [31:0] axi_wdata;
  logic [3:0]  axi_wstrb;
  logic        axi_bvalid;
  logic        axi_bready;
  logic        axi_arvalid;
  logic        axi_arready;
  logic [31:0] axi_araddr;
  logic        axi_rvalid;
  logic        axi_rready;
  logic [31:0] axi_rdata;

  modport master (
    input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata,
    output axi_awvalid, axi_awaddr, axi_wvalid, axi_wdata, axi_wstrb, axi_bready,
    output axi_arvalid, axi_araddr, axi_rready,
    input  axi_awready, axi_wready, axi_bvalid, axi_arready, axi_rvalid, axi_rdata
  );

  modport slave (
    output mem_valid, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata,
    input  axi_awvalid, axi_awaddr, axi_wvalid, axi_wdata, axi_wstrb, axi_bready,
    input  axi_arvalid, axi_araddr, axi_rready,
    output axi_awready, axi_wready, axi_bvalid, axi_arready, axi_rvalid, axi_rdata
  );
endinterface

// File: rtl/native_axil_bridge.sv
// Native mem_valid/mem_ready port to AXI4-Lite master, one transaction in flight.
// Requests outside the RAM window complete locally with a sticky bus_err.
module native_axil_bridge #(
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter logic [31:0] ADDR_SIZE = 32'h0000_4000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  native_axil_bridge_if.master bus,
  output logic                 bus_err,
  output logic [2:0]           state_dbg
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d;
  logic        bready_q, bready_d;
  logic        arvalid_q, arvalid_d;
  logic        rready_q, rready_d;
  logic        mem_ready_q, mem_ready_d;
  logic [31:0] mem_rdata_q, mem_rdata_d;
  logic        err_q, err_d;

  // 33-bit bounds so a window ending exactly at 2^32 does not wrap to zero.
  logic [32:0] win_lo, win_hi, req_addr;
  logic        in_window;

  assign win_lo    = {1'b0, ADDR_BASE};
  assign win_hi    = {1'b0, ADDR_BASE} + {1'b0, ADDR_SIZE};
  assign req_addr  = {1'b0, bus.mem_addr};
  assign in_window = (req_addr >= win_lo) && (req_addr < win_hi);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    mem_ready_d = 1'b0;
    mem_rdata_d = mem_rdata_q;
    err_d       = err_q;
    unique case (state_q)
      IDLE: begin
        if (bus.mem_valid) begin
          addr_d  = bus.mem_addr;
          wdata_d = bus.mem_wdata;
          wstrb_d = bus.mem_wstrb;
          if (!in_window) begin
            state_d     = DONE;
            mem_ready_d = 1'b1;
            mem_rdata_d = 32'h0;
            err_d       = 1'b1;
          end else if (bus.mem_wstrb != 4'b0000) begin
            state_d   = WR_REQ;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = RD_REQ;
            arvalid_d = 1'b1;
          end
        end
      end
      WR_REQ: begin
        // Address and data channels retire independently; leave once both have.
        if (awvalid_q && bus.axi_awready) awvalid_d = 1'b0;
        if (wvalid_q && bus.axi_wready)   wvalid_d  = 1'b0;
        if ((!awvalid_q || bus.axi_awready) && (!wvalid_q || bus.axi_wready)) begin
          state_d  = WR_RESP;
          bready_d = 1'b1;
        end
      end
      WR_RESP: begin
        if (bus.axi_bvalid) begin
          state_d     = DONE;
          bready_d    = 1'b0;
          mem_ready_d = 1'b1;
        end
      end
      RD_REQ: begin
        if (bus.axi_arready) begin
          state_d   = RD_RESP;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
      end
      RD_RESP: begin
        if (bus.axi_rvalid) begin
          state_d     = DONE;
          rready_d    = 1'b0;
          mem_rdata_d = bus.axi_rdata;
          mem_ready_d = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      wstrb_q     <= 4'h0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      mem_ready_q <= 1'b0;
      mem_rdata_q <= 32'h0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      mem_ready_q <= mem_ready_d;
      mem_rdata_q <= mem_rdata_d;
      err_q       <= err_d;
    end
  end

  assign bus.axi_awvalid = awvalid_q;
  assign bus.axi_awaddr  = addr_q;
  assign bus.axi_wvalid  = wvalid_q;
  assign bus.axi_wdata   = wdata_q;
  assign bus.axi_wstrb   = wstrb_q;
  assign bus.axi_bready  = bready_q;
  assign bus.axi_arvalid = arvalid_q;
  assign bus.axi_araddr  = addr_q;
  assign bus.axi_rready  = rready_q;
  assign bus.mem_ready   = mem_ready_q;
  assign bus.mem_rdata   = mem_rdata_q;
  assign bus_err         = err_q;
  assign state_dbg       = state_q;

endmodule

// File: tb/tb_native_axil_bridge.sv
// Bench for native_axil_bridge: core driver, AXI RAM slave with programmable stalls,
// bus monitor, and a word-level memory model predicting data, latency and error.
module tb_native_axil_bridge;

  localparam longint WIN_BASE = 64'h0;
  localparam longint WIN_SIZE = 64'h4000;

  logic       clk;
  logic       rst_n;
  logic       bus_err;
  logic [2:0] state_dbg;

  native_axil_bridge_if bus ();

  native_axil_bridge #(.ADDR_BASE(32'h0000_0000), .ADDR_SIZE(32'h0000_4000)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .bus_err(bus_err), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [int];
  logic [31:0] ref_rdata;
  logic        ref_err;
  logic [31:0] exp_q[$];

  function automatic bit ref_in_window(input logic [31:0] a);
    longint la = longint'(a);
    return (la >= WIN_BASE) && (la < WIN_BASE + WIN_SIZE);
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    int key = int'(a[31:2]);
    return ref_mem.exists(key) ? ref_mem[key] : 32'h0;
  endfunction

  task automatic ref_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] cur = ref_read(a);
    for (int b = 0; b < 4; b++) if (s[b]) cur[8*b +: 8] = d[8*b +: 8];
    ref_mem[int'(a[31:2])] = cur;
  endtask

  // ---------------- AXI RAM slave ----------------
  int aw_delay, w_delay, b_delay, ar_delay, r_delay;
  logic [31:0] ram [0:4095];

  initial begin : wr_slave
    int aw_cnt, w_cnt;
    bit aw_have, w_have;
    logic [31:0] s_addr, s_data;
    logic [3:0]  s_strb;
    for (int i = 0; i < 4096; i++) ram[i] = 32'h0;
    aw_cnt = 0; w_cnt = 0; aw_have = 0; w_have = 0;
    s_addr = 0; s_data = 0; s_strb = 0;
    bus.axi_awready = 0; bus.axi_wready = 0; bus.axi_bvalid = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bus.axi_awready = 0; bus.axi_wready = 0; bus.axi_bvalid = 0;
        aw_have = 0; w_have = 0; aw_cnt = 0; w_cnt = 0;
        continue;
      end
      if (bus.axi_awvalid && !aw_have && aw_cnt >= aw_delay) begin
        bus.axi_awready = 1; aw_have = 1; s_addr = bus.axi_awaddr; aw_cnt = 0;
      end else begin
        bus.axi_awready = 0;
        if (bus.axi_awvalid && !aw_have) aw_cnt++;
      end
      if (bus.axi_wvalid && !w_have && w_cnt >= w_delay) begin
        bus.axi_wready = 1; w_have = 1; s_data = bus.axi_wdata; s_strb = bus.axi_wstrb; w_cnt = 0;
      end else begin
        bus.axi_wready = 0;
        if (bus.axi_wvalid && !w_have) w_cnt++;
      end
      if (aw_have && w_have) begin
        for (int b = 0; b < 4; b++) if (s_strb[b]) ram[s_addr[13:2]][8*b +: 8] = s_data[8*b +: 8];
        aw_have = 0; w_have = 0;
        @(posedge clk); #1;
        bus.axi_awready = 0; bus.axi_wready = 0;
        for (int i = 0; i < b_delay; i++) begin
          @(posedge clk);
          if (!rst_n) break;
        end
        if (rst_n) begin
          #1 bus.axi_bvalid = 1;
          for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            if (!rst_n || bus.axi_bready) break;
          end
          #1 bus.axi_bvalid = 0;
        end
      end
    end
  end

  initial begin : rd_slave
    int ar_cnt;
    logic [31:0] r_addr;
    ar_cnt = 0; r_addr = 0;
    bus.axi_arready = 0; bus.axi_rvalid = 0; bus.axi_rdata = $urandom;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bus.axi_arready = 0; bus.axi_rvalid = 0; ar_cnt = 0;
        continue;
      end
      if (bus.axi_arvalid && ar_cnt >= ar_delay) begin
        bus.axi_arready = 1; r_addr = bus.axi_araddr; ar_cnt = 0;
        @(posedge clk); #1;
        bus.axi_arready = 0;
        for (int i = 0; i < r_delay; i++) begin
          @(posedge clk);
          if (!rst_n) break;
        end
        if (rst_n) begin
          #1 bus.axi_rvalid = 1; bus.axi_rdata = ram[r_addr[13:2]];
          for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            if (!rst_n || bus.axi_rready) break;
          end
          #1 bus.axi_rvalid = 0; bus.axi_rdata = $urandom;
        end
      end else begin
        bus.axi_arready = 0;
        if (bus.axi_arvalid) ar_cnt++;
      end
    end
  end

  // ---------------- bus monitor (cumulative counters) ----------------
  int cyc = 0, valid_seen = 0, ready_pulses = 0, proto_err = 0, ar_cycles = 0;
  int n_aw_hs = 0, n_w_hs = 0, n_ar_hs = 0;
  int aw_rise = 0, w_rise = 0, aw_end = 0, w_end = 0;
  logic [31:0] hs_awaddr = 0, hs_wdata = 0, hs_araddr = 0;
  logic [3:0]  hs_wstrb = 0;
  logic p_aw = 0, p_awr = 0, p_w = 0, p_wr = 0, p_ar = 0, p_arr = 0;
  logic [31:0] p_awaddr = 0, p_wdata = 0, p_araddr = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_aw <= 0; p_awr <= 0; p_w <= 0; p_wr <= 0; p_ar <= 0; p_arr <= 0;
    end else begin
      cyc <= cyc + 1;
      if (bus.axi_awvalid || bus.axi_wvalid || bus.axi_arvalid) valid_seen <= valid_seen + 1;
      if (bus.mem_ready) ready_pulses <= ready_pulses + 1;
      proto_err <= proto_err
        + int'(p_aw && !p_awr && (!bus.axi_awvalid || bus.axi_awaddr !== p_awaddr))
        + int'(p_w  && !p_wr  && (!bus.axi_wvalid  || bus.axi_wdata  !== p_wdata))
        + int'(p_ar && !p_arr && (!bus.axi_arvalid || bus.axi_araddr !== p_araddr));
      if (bus.axi_awvalid && !p_aw) aw_rise <= cyc;
      if (bus.axi_wvalid && !p_w)   w_rise  <= cyc;
      if (bus.axi_awvalid) aw_end <= cyc;
      if (bus.axi_wvalid)  w_end  <= cyc;
      if (bus.axi_arvalid) ar_cycles <= ar_cycles + 1;
      if (bus.axi_awvalid && bus.axi_awready) begin n_aw_hs <= n_aw_hs + 1; hs_awaddr <= bus.axi_awaddr; end
      if (bus.axi_wvalid && bus.axi_wready) begin
        n_w_hs <= n_w_hs + 1; hs_wdata <= bus.axi_wdata; hs_wstrb <= bus.axi_wstrb;
      end
      if (bus.axi_arvalid && bus.axi_arready) begin n_ar_hs <= n_ar_hs + 1; hs_araddr <= bus.axi_araddr; end
      p_aw <= bus.axi_awvalid; p_awr <= bus.axi_awready; p_awaddr <= bus.axi_awaddr;
      p_w  <= bus.axi_wvalid;  p_wr  <= bus.axi_wready;  p_wdata  <= bus.axi_wdata;
      p_ar <= bus.axi_arvalid; p_arr <= bus.axi_arready; p_araddr <= bus.axi_araddr;
    end
  end

  // ---------------- core-side driver ----------------
  // Latency counts cycles from the one mem_valid rises in to the one mem_ready is high in.
  task automatic drive_txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [31:0] rd, output int lat, output bit ok);
    @(posedge clk); #1;
    bus.mem_valid = 1; bus.mem_addr = a; bus.mem_wdata = d; bus.mem_wstrb = s;
    lat = 1; ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.mem_ready) begin ok = 1; break; end
      lat++;
      if (lat >= 3) begin
        bus.mem_addr = $urandom; bus.mem_wdata = $urandom; bus.mem_wstrb = 4'($urandom);
      end
    end
    rd = bus.mem_rdata;
    @(posedge clk); #1;
    bus.mem_valid = 0;
  endtask

  task automatic set_delays(input int aw, input int w, input int b, input int ar, input int r);
    aw_delay = aw; w_delay = w; b_delay = b; ar_delay = ar; r_delay = r;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1;
    bus.mem_valid = 0; bus.mem_addr = 0; bus.mem_wdata = 0; bus.mem_wstrb = 0;
    set_delays(0, 0, 0, 0, 0);
    #3 rst_n = 0;
    #1;
    n_checks++; if ({bus.axi_awvalid, bus.axi_wvalid, bus.axi_bready, bus.axi_arvalid, bus.axi_rready,
                     bus.mem_ready, bus_err} !== 7'b0)
      $display("FAIL reset_ctrl got %b want 0000000", {bus.axi_awvalid, bus.axi_wvalid, bus.axi_bready,
               bus.axi_arvalid, bus.axi_rready, bus.mem_ready, bus_err}); else n_pass++;
    n_checks++; if (bus.mem_rdata !== 32'h0) $display("FAIL reset_rdata got %h want 0", bus.mem_rdata); else n_pass++;
    n_checks++; if ({bus.axi_awaddr, bus.axi_wdata, bus.axi_wstrb} !== 68'h0)
      $display("FAIL reset_latched got %h/%h/%h want 0", bus.axi_awaddr, bus.axi_wdata, bus.axi_wstrb); else n_pass++;
    repeat (3) @(negedge clk);
    rst_n = 1;
    ref_rdata = 0; ref_err = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write_basic();
    logic [31:0] rd; int lat; bit ok;
    int aw0 = n_aw_hs, w0 = n_w_hs, rp0 = ready_pulses;
    set_delays(0, 0, 0, 0, 0);
    drive_txn(32'h10, 32'hA5A5_1234, 4'hF, rd, lat, ok);
    ref_write(32'h10, 32'hA5A5_1234, 4'hF);
    n_checks++; if (!ok || lat != 4) $display("FAIL wr_latency got %0d (done=%0d) want 4", lat, ok); else n_pass++;
    n_checks++; if (n_aw_hs - aw0 != 1 || n_w_hs - w0 != 1)
      $display("FAIL wr_handshakes got aw=%0d w=%0d want 1/1", n_aw_hs - aw0, n_w_hs - w0); else n_pass++;
    n_checks++; if (hs_awaddr !== 32'h10) $display("FAIL wr_awaddr got %h want 00000010", hs_awaddr); else n_pass++;
    n_checks++; if ({hs_wdata, hs_wstrb} !== {32'hA5A5_1234, 4'hF})
      $display("FAIL wr_wdata got %h/%h want a5a51234/f", hs_wdata, hs_wstrb); else n_pass++;
    n_checks++; if (aw_rise != w_rise) $display("FAIL wr_aw_w_together got aw@%0d w@%0d", aw_rise, w_rise); else n_pass++;
    n_checks++; if (ready_pulses - rp0 != 1) $display("FAIL wr_ready_pulse got %0d want 1", ready_pulses - rp0); else n_pass++;
    n_checks++; if (rd !== ref_rdata) $display("FAIL wr_rdata_hold got %h want %h", rd, ref_rdata); else n_pass++;
  endtask

  task automatic test_read_basic();
    logic [31:0] rd; int lat; bit ok; logic [31:0] exp;
    exp_q.push_back(ref_read(32'h10));
    drive_txn(32'h10, 32'h0, 4'h0, rd, lat, ok);
    exp = exp_q.pop_front(); ref_rdata = exp;
    n_checks++; if (rd !== exp) $display("FAIL rd_data got %h want %h", rd, exp); else n_pass++;
    n_checks++; if (!ok || lat != 4) $display("FAIL rd_latency got %0d want 4", lat); else n_pass++;
    n_checks++; if (hs_araddr !== 32'h10) $display("FAIL rd_araddr got %h want 00000010", hs_araddr); else n_pass++;
    n_checks++; if (bus_err !== 1'b0) $display("FAIL rd_bus_err got %b want 0", bus_err); else n_pass++;
  endtask

  task automatic test_partial_write();
    logic [31:0] rd; int lat; bit ok; logic [31:0] exp;
    int pe0 = proto_err;
    set_delays(0, 1, 0, 0, 0);
    drive_txn(32'h10, 32'hFFFF_FFFF, 4'h2, rd, lat, ok);
    ref_write(32'h10, 32'hFFFF_FFFF, 4'h2);
    n_checks++; if (!ok || lat != 5) $display("FAIL pw_latency got %0d want 5", lat); else n_pass++;
    n_checks++; if (w_end - aw_end != 1) $display("FAIL pw_aw_first got aw_end=%0d w_end=%0d want diff 1", aw_end, w_end); else n_pass++;
    n_checks++; if (proto_err != pe0) $display("FAIL pw_protocol got %0d violations want 0", proto_err - pe0); else n_pass++;
    n_checks++; if (rd !== ref_rdata) $display("FAIL pw_rdata_hold got %h want %h", rd, ref_rdata); else n_pass++;
    set_delays(0, 0, 0, 0, 0);
    exp_q.push_back(ref_read(32'h10));
    drive_txn(32'h10, 32'h0, 4'h0, rd, lat, ok);
    exp = exp_q.pop_front(); ref_rdata = exp;
    n_checks++; if (rd !== exp) $display("FAIL pw_readback got %h want %h", rd, exp); else n_pass++;
  endtask

  task automatic test_out_of_window();
    logic [31:0] rd; int lat; bit ok; logic [31:0] exp;
    int vs0 = valid_seen;
    drive_txn(32'h0000_4000, 32'h0, 4'h0, rd, lat, ok);
    ref_rdata = 0; ref_err = 1;
    n_checks++; if (!ok || lat != 2) $display("FAIL oow_rd_latency got %0d want 2", lat); else n_pass++;
    n_checks++; if (rd !== 32'h0) $display("FAIL oow_rd_data got %h want 0", rd); else n_pass++;
    n_checks++; if (bus_err !== ref_err) $display("FAIL oow_bus_err got %b want %b", bus_err, ref_err); else n_pass++;
    drive_txn(32'hFFFF_FFFC, 32'h1234_5678, 4'hF, rd, lat, ok);
    n_checks++; if (!ok || lat != 2) $display("FAIL oow_wr_latency got %0d want 2", lat); else n_pass++;
    n_checks++; if (valid_seen != vs0) $display("FAIL oow_no_axi got %0d valid cycles want 0", valid_seen - vs0); else n_pass++;
    drive_txn(32'h0000_3FFC, 32'hCAFE_F00D, 4'hF, rd, lat, ok);
    ref_write(32'h3FFC, 32'hCAFE_F00D, 4'hF);
    n_checks++; if (!ok || lat != 4) $display("FAIL edge_wr_latency got %0d want 4", lat); else n_pass++;
    exp_q.push_back(ref_read(32'h3FFC));
    drive_txn(32'h0000_3FFC, 32'h0, 4'h0, rd, lat, ok);
    exp = exp_q.pop_front(); ref_rdata = exp;
    n_checks++; if (rd !== exp) $display("FAIL edge_rd_data got %h want %h", rd, exp); else n_pass++;
    n_checks++; if (bus_err !== 1'b1) $display("FAIL err_sticky got %b want 1", bus_err); else n_pass++;
  endtask

  task automatic test_read_stall();
    logic [31:0] rd; int lat; bit ok; logic [31:0] exp;
    int pe0 = proto_err, rp0 = ready_pulses, ac0 = ar_cycles;
    set_delays(0, 0, 0, 5, 3);
    exp_q.push_back(ref_read(32'h3FFC));
    drive_txn(32'h3FFC, 32'h0, 4'h0, rd, lat, ok);
    exp = exp_q.pop_front(); ref_rdata = exp;
    n_checks++; if (rd !== exp) $display("FAIL stall_data got %h want %h", rd, exp); else n_pass++;
    n_checks++; if (!ok || lat != 12) $display("FAIL stall_latency got %0d want 12", lat); else n_pass++;
    n_checks++; if (ar_cycles - ac0 != 6) $display("FAIL stall_arvalid_cycles got %0d want 6", ar_cycles - ac0); else n_pass++;
    n_checks++; if (proto_err != pe0) $display("FAIL stall_protocol got %0d violations want 0", proto_err - pe0); else n_pass++;
    n_checks++; if (ready_pulses - rp0 != 1) $display("FAIL stall_ready_pulse got %0d want 1", ready_pulses - rp0); else n_pass++;
    set_delays(0, 0, 0, 0, 0);
  endtask

  task automatic test_random();
    logic [31:0] rd, a, d, exp; logic [3:0] s; int lat, exp_lat, kind, vs0, pe0; bit ok;
    for (int i = 0; i < 40; i++) begin
      set_delays($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 3));
      kind = $urandom_range(0, 9);
      d = $urandom;
      if (kind == 0) a = $urandom_range(32'h0000_4000, 32'hFFFF_FFFF);
      else a = 32'($urandom_range(0, 31)) << 2;
      s = (kind >= 5) ? 4'h0 : 4'($urandom_range(1, 15));
      vs0 = valid_seen; pe0 = proto_err;
      if (!ref_in_window(a)) begin
        exp_lat = 2; exp = 32'h0; ref_err = 1;
      end else if (s != 0) begin
        exp_lat = 4 + ((aw_delay > w_delay) ? aw_delay : w_delay) + b_delay;
        exp = ref_rdata;
        ref_write(a, d, s);
      end else begin
        exp_lat = 4 + ar_delay + r_delay;
        exp_q.push_back(ref_read(a));
        exp = exp_q.pop_front();
      end
      ref_rdata = exp;
      drive_txn(a, d, s, rd, lat, ok);
      n_checks++; if (!ok || lat != exp_lat) $display("FAIL rnd%0d_latency got %0d want %0d", i, lat, exp_lat); else n_pass++;
      n_checks++; if (rd !== exp) $display("FAIL rnd%0d_rdata got %h want %h", i, rd, exp); else n_pass++;
      n_checks++; if (bus_err !== ref_err) $display("FAIL rnd%0d_bus_err got %b want %b", i, bus_err, ref_err); else n_pass++;
      n_checks++; if (proto_err != pe0) $display("FAIL rnd%0d_protocol got %0d violations", i, proto_err - pe0); else n_pass++;
      if (!ref_in_window(a)) begin
        n_checks++; if (valid_seen != vs0) $display("FAIL rnd%0d_no_axi got %0d want 0", i, valid_seen - vs0); else n_pass++;
      end else if (s != 0) begin
        n_checks++; if (hs_awaddr !== a) $display("FAIL rnd%0d_awaddr got %h want %h", i, hs_awaddr, a); else n_pass++;
      end else begin
        n_checks++; if (hs_araddr !== a) $display("FAIL rnd%0d_araddr got %h want %h", i, hs_araddr, a); else n_pass++;
      end
    end
    set_delays(0, 0, 0, 0, 0);
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd, exp, d; int lat; bit ok, seen;
    set_delays(0, 0, 6, 0, 0);
    d = $urandom;
    @(posedge clk); #1;
    bus.mem_valid = 1; bus.mem_addr = 32'h100; bus.mem_wdata = d; bus.mem_wstrb = 4'hF;
    ref_write(32'h100, d, 4'hF);
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.axi_bready) begin seen = 1; break; end
    end
    n_checks++; if (!seen) $display("FAIL rstmid_reach_resp got bready=0 want 1"); else n_pass++;
    #2 rst_n = 0; bus.mem_valid = 0;
    #1;
    n_checks++; if ({bus.axi_awvalid, bus.axi_wvalid, bus.axi_bready, bus.axi_arvalid, bus.axi_rready,
                     bus.mem_ready} !== 6'b0)
      $display("FAIL rstmid_ctrl got %b want 000000", {bus.axi_awvalid, bus.axi_wvalid, bus.axi_bready,
               bus.axi_arvalid, bus.axi_rready, bus.mem_ready}); else n_pass++;
    ref_err = 0; ref_rdata = 0;
    n_checks++; if (bus_err !== ref_err) $display("FAIL rstmid_bus_err got %b want %b", bus_err, ref_err); else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1;
    set_delays(0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    exp_q.push_back(ref_read(32'h10));
    drive_txn(32'h10, 32'h0, 4'h0, rd, lat, ok);
    exp = exp_q.pop_front();
    n_checks++; if (rd !== exp) $display("FAIL rstmid_read got %h want %h", rd, exp); else n_pass++;
    n_checks++; if (!ok || lat != 4) $display("FAIL rstmid_latency got %0d want 4", lat); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_read_basic();
    test_partial_write();
    test_out_of_window();
    test_read_stall();
    test_random();
    test_reset_mid();
    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
